mouse_frame_sampler: RTL and testbench
======================================

Name: mouse_frame_sampler

Overview:
- Controller for the mouse register stage feeding the game logic.
- Samples the registered mouse/secondary-player data once per frame, at the rising edge of vertical blank.
- Waits for the inputs to stay stable across consecutive cycles, clamps the paddle positions, detects the click edge and commits a coherent snapshot with a one-cycle strobe.
- Keeps paddle positions from changing mid-frame and rejects torn multi-bit values.

Parameters:
- STABLE_CYCLES, 2, consecutive matching cycles required before commit (1..15).
- TIMEOUT, 16, max cycles in SETTLE before abort (STABLE_CYCLES < TIMEOUT <= 255).
- Y_MAX, 668, upper clamp for ypos_out (768 lines minus 100-line paddle).
- Y_MAX_SEC, 668, upper clamp for ypos_out_sec.

Ports:
- clk  in  1  pixel-domain clock.
- rst  in  1  synchronous reset, active-high.
- vblank_in  in  1  vertical blank level from timing generator.
- xpos_in  in  12  mouse x from register stage.
- ypos_in  in  12  mouse y from register stage.
- ypos_in_sec  in  10  second player y.
- mouse_left_in  in  1  left button level.
- xpos_out  out  12  committed x, unclamped.
- ypos_out  out  12  committed, clamped y.
- ypos_out_sec  out  10  committed, clamped second-player y.
- click_pulse  out  1  one-cycle pulse on a committed press.
- sample_valid  out  1  one-cycle strobe when new values first appear.
- sample_err  out  1  one-cycle strobe on a SETTLE timeout.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: all outputs 0, state IDLE, vblank_d 0, snapshot/counters 0, committed button state 0.
- Edge detect: vblank_d registers vblank_in; edge = vblank_in & ~vblank_d.
- IDLE:
  - On edge at cycle T: snapshot <= {xpos_in, ypos_in, ypos_in_sec, mouse_left_in}; stable_cnt <= 0; timer <= 0; go to SETTLE.
- SETTLE, each cycle:
  - timer increments.
  - If inputs equal snapshot: stable_cnt++. When stable_cnt == STABLE_CYCLES-1 on a match, go to COMMIT.
  - If inputs differ from snapshot: snapshot <= inputs; stable_cnt <= 0.
  - If timer == TIMEOUT-1 and no match-commit occurs that cycle: go to ABORT. A commit in the same cycle wins.
  - Further vblank edges are ignored.
- COMMIT (1 cycle), using the snapshot:
  - xpos_out <= x.
  - ypos_out <= min(y, Y_MAX), 12-bit unsigned compare.
  - ypos_out_sec <= min(ysec, Y_MAX_SEC), 10-bit compare.
  - click_pulse <= btn & ~btn_committed; btn_committed <= btn.
  - sample_valid <= 1.
  - Next state IDLE.
- ABORT (1 cycle): outputs hold previous values; sample_err <= 1; click_pulse 0; next state IDLE.
- Pulse width: sample_valid, sample_err and click_pulse are registered and high for exactly one cycle; never both valid and err.
- Latency: with inputs stable from T, sample_valid is high at T+STABLE_CYCLES+2, the same cycle the new outputs are first visible.
- Outputs change only in the cycle after COMMIT; otherwise they hold.
- vblank held high for many frames produces a single sample; a new sample needs a low-then-high transition.
- If an edge coincides with the ABORT/COMMIT cycle it is missed; the next sample comes at the next frame.
- rst asserted in any state: next cycle IDLE with reset values; in-flight sample discarded, no strobe.

Test Plan:
- Reset with inputs x=100, y=200 -> all outputs 0; after release and no vblank edge, outputs stay 0.
- vblank rises at T, inputs constant x=300, y=400, ysec=50, btn=0 -> sample_valid only at T+4 (defaults), xpos_out=300, ypos_out=400, ypos_out_sec=50.
- y=700, ysec=1000 stable, then vblank edge -> ypos_out=668, ypos_out_sec=668, sample_valid pulse.
- ypos_in toggles 10/11 every cycle after an edge -> sample_err at T+TIMEOUT+1, outputs keep prior values, no sample_valid. Next frame with stable y=11 -> ypos_out=11.
- btn=1 on two consecutive frames -> click_pulse on first commit only; btn 0 then 1 -> pulse again.
- rst pulsed at T+2 mid-SETTLE -> no strobes, outputs 0; next vblank edge samples normally.

Source files
------------

// File: rtl/mouse_frame_sampler.sv
// mouse_frame_sampler: once per frame, at the rising edge of vertical blank,
// waits for the mouse / second-player inputs to hold steady, then commits a
// clamped, coherent snapshot together with one-cycle strobes.
module mouse_frame_sampler #(
  parameter int unsigned STABLE_CYCLES = 2,
  parameter int unsigned TIMEOUT       = 16,
  parameter logic [11:0] Y_MAX         = 12'd668,
  parameter logic [9:0]  Y_MAX_SEC     = 10'd668
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vblank_in,
  input  logic [11:0] xpos_in,
  input  logic [11:0] ypos_in,
  input  logic [9:0]  ypos_in_sec,
  input  logic        mouse_left_in,
  output logic [11:0] xpos_out,
  output logic [11:0] ypos_out,
  output logic [9:0]  ypos_out_sec,
  output logic        click_pulse,
  output logic        sample_valid,
  output logic        sample_err
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_COMMIT = 2'd2,
    ST_ABORT  = 2'd3
  } state_t;

  // Last stable count before commit, and the timer value whose increment
  // reaches TIMEOUT-1 (the abort decision looks at the incremented timer).
  localparam logic [3:0] STABLE_LAST = 4'(STABLE_CYCLES - 1);
  localparam logic [7:0] TIMER_LAST  = 8'(TIMEOUT - 2);

  state_t      state_r;
  logic        vblank_d_r;
  logic [34:0] snap_r;
  logic [3:0]  stable_cnt_r;
  logic [7:0]  timer_r;
  logic        btn_committed_r;

  logic [34:0] inputs_s;
  logic        match_s;
  logic        vblank_edge_s;
  logic [11:0] snap_x_s;
  logic [11:0] snap_y_s;
  logic [9:0]  snap_ysec_s;
  logic        snap_btn_s;
  logic [11:0] y_clamp_s;
  logic [9:0]  ysec_clamp_s;

  // Input bundle, stability compare, vblank edge and clamping of the snapshot
  always_comb begin
    inputs_s      = {xpos_in, ypos_in, ypos_in_sec, mouse_left_in};
    match_s       = (inputs_s == snap_r);
    vblank_edge_s = vblank_in & ~vblank_d_r;
    snap_x_s      = snap_r[34:23];
    snap_y_s      = snap_r[22:11];
    snap_ysec_s   = snap_r[10:1];
    snap_btn_s    = snap_r[0];
    if (snap_y_s > Y_MAX) begin
      y_clamp_s = Y_MAX;
    end else begin
      y_clamp_s = snap_y_s;
    end
    if (snap_ysec_s > Y_MAX_SEC) begin
      ysec_clamp_s = Y_MAX_SEC;
    end else begin
      ysec_clamp_s = snap_ysec_s;
    end
  end

  // Sampling FSM with registered outputs and one-cycle strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r         <= ST_IDLE;
      vblank_d_r      <= 1'b0;
      snap_r          <= 35'd0;
      stable_cnt_r    <= 4'd0;
      timer_r         <= 8'd0;
      btn_committed_r <= 1'b0;
      xpos_out        <= 12'd0;
      ypos_out        <= 12'd0;
      ypos_out_sec    <= 10'd0;
      click_pulse     <= 1'b0;
      sample_valid    <= 1'b0;
      sample_err      <= 1'b0;
    end else begin
      vblank_d_r   <= vblank_in;
      click_pulse  <= 1'b0;
      sample_valid <= 1'b0;
      sample_err   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (vblank_edge_s) begin
            snap_r       <= inputs_s;
            stable_cnt_r <= 4'd0;
            timer_r      <= 8'd0;
            state_r      <= ST_SETTLE;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_SETTLE: begin
          timer_r <= timer_r + 8'd1;
          if (match_s && (stable_cnt_r == STABLE_LAST)) begin
            // A commit in the timeout cycle takes priority over the abort.
            state_r <= ST_COMMIT;
          end else begin
            if (match_s) begin
              stable_cnt_r <= stable_cnt_r + 4'd1;
            end else begin
              snap_r       <= inputs_s;
              stable_cnt_r <= 4'd0;
            end
            if (timer_r == TIMER_LAST) begin
              state_r <= ST_ABORT;
            end else begin
              state_r <= ST_SETTLE;
            end
          end
        end
        ST_COMMIT: begin
          xpos_out        <= snap_x_s;
          ypos_out        <= y_clamp_s;
          ypos_out_sec    <= ysec_clamp_s;
          click_pulse     <= snap_btn_s & ~btn_committed_r;
          btn_committed_r <= snap_btn_s;
          sample_valid    <= 1'b1;
          state_r         <= ST_IDLE;
        end
        ST_ABORT: begin
          sample_err <= 1'b1;
          state_r    <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mouse_frame_sampler.sv
// Directed self-checking bench for mouse_frame_sampler (default parameters).
module tb_mouse_frame_sampler;

  logic        clk;
  logic        rst;
  logic        vblank_in;
  logic [11:0] xpos_in;
  logic [11:0] ypos_in;
  logic [9:0]  ypos_in_sec;
  logic        mouse_left_in;
  logic [11:0] xpos_out;
  logic [11:0] ypos_out;
  logic [9:0]  ypos_out_sec;
  logic        click_pulse;
  logic        sample_valid;
  logic        sample_err;

  int tests_run;
  int tests_failed;

  mouse_frame_sampler dut (
    .clk          (clk),
    .rst          (rst),
    .vblank_in    (vblank_in),
    .xpos_in      (xpos_in),
    .ypos_in      (ypos_in),
    .ypos_in_sec  (ypos_in_sec),
    .mouse_left_in(mouse_left_in),
    .xpos_out     (xpos_out),
    .ypos_out     (ypos_out),
    .ypos_out_sec (ypos_out_sec),
    .click_pulse  (click_pulse),
    .sample_valid (sample_valid),
    .sample_err   (sample_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives vblank low for two cycles, then raises it (T = this moment).
  task automatic start_frame();
    vblank_in = 1'b0;
    step();
    step();
    vblank_in = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; vblank_in = 1'b0; xpos_in = 12'd100; ypos_in = 12'd200;
    ypos_in_sec = 10'd0; mouse_left_in = 1'b0;
    step(); step(); step();
    tests_run++;
    if ({xpos_out, ypos_out, ypos_out_sec, click_pulse, sample_valid, sample_err} !== 37'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got x=%0d y=%0d ys=%0d clk=%b v=%b e=%b, want all 0",
               xpos_out, ypos_out, ypos_out_sec, click_pulse, sample_valid, sample_err);
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      tests_run++;
      if ({xpos_out, ypos_out, ypos_out_sec, click_pulse, sample_valid, sample_err} !== 37'd0) begin
        tests_failed++;
        $display("FAIL reset_idle_hold cyc%0d: got x=%0d y=%0d v=%b e=%b, want all 0",
                 i, xpos_out, ypos_out, sample_valid, sample_err);
      end
    end
  endtask

  task automatic test_basic_sample();
    xpos_in = 12'd300; ypos_in = 12'd400; ypos_in_sec = 10'd50; mouse_left_in = 1'b0;
    start_frame();
    for (int i = 1; i <= 6; i++) begin
      step();
      tests_run++;
      if (sample_valid !== (i == 4) || sample_err !== 1'b0) begin
        tests_failed++;
        $display("FAIL basic_strobe T+%0d: got v=%b e=%b, want v=%b e=0",
                 i, sample_valid, sample_err, (i == 4));
      end
      if (i == 4) begin
        tests_run++;
        if (xpos_out !== 12'd300 || ypos_out !== 12'd400 || ypos_out_sec !== 10'd50) begin
          tests_failed++;
          $display("FAIL basic_values: got x=%0d y=%0d ys=%0d, want 300 400 50",
                   xpos_out, ypos_out, ypos_out_sec);
        end
      end else if (i < 4) begin
        tests_run++;
        if (xpos_out !== 12'd0 || ypos_out !== 12'd0) begin
          tests_failed++;
          $display("FAIL basic_early_change T+%0d: got x=%0d y=%0d, want 0 0",
                   i, xpos_out, ypos_out);
        end
      end
    end
  endtask

  task automatic test_clamp();
    xpos_in = 12'd4095; ypos_in = 12'd700; ypos_in_sec = 10'd1000;
    start_frame();
    for (int i = 1; i <= 6; i++) begin
      step();
      tests_run++;
      if (sample_valid !== (i == 4)) begin
        tests_failed++;
        $display("FAIL clamp_strobe T+%0d: got v=%b, want %b", i, sample_valid, (i == 4));
      end
      if (i == 4) begin
        tests_run++;
        if (xpos_out !== 12'd4095 || ypos_out !== 12'd668 || ypos_out_sec !== 10'd668) begin
          tests_failed++;
          $display("FAIL clamp_values: got x=%0d y=%0d ys=%0d, want 4095 668 668",
                   xpos_out, ypos_out, ypos_out_sec);
        end
      end
    end
    // Exactly at the limit passes through unchanged.
    ypos_in = 12'd668; ypos_in_sec = 10'd667;
    start_frame();
    for (int i = 1; i <= 4; i++) step();
    tests_run++;
    if (sample_valid !== 1'b1 || ypos_out !== 12'd668 || ypos_out_sec !== 10'd667) begin
      tests_failed++;
      $display("FAIL clamp_boundary: got v=%b y=%0d ys=%0d, want 1 668 667",
               sample_valid, ypos_out, ypos_out_sec);
    end
    step(); step();
  endtask

  task automatic test_timeout();
    xpos_in = 12'd5; ypos_in = 12'd10; ypos_in_sec = 10'd7; mouse_left_in = 1'b0;
    start_frame();
    for (int i = 1; i <= 20; i++) begin
      ypos_in = (i % 2 == 1) ? 12'd11 : 12'd10;
      step();
      tests_run++;
      if (sample_err !== (i == 17) || sample_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL timeout_strobe T+%0d: got e=%b v=%b, want e=%b v=0",
                 i, sample_err, sample_valid, (i == 17));
      end
      tests_run++;
      if (xpos_out !== 12'd4095 || ypos_out !== 12'd668 || ypos_out_sec !== 10'd667) begin
        tests_failed++;
        $display("FAIL timeout_hold T+%0d: got x=%0d y=%0d ys=%0d, want 4095 668 667",
                 i, xpos_out, ypos_out, ypos_out_sec);
      end
    end
    ypos_in = 12'd11;
    start_frame();
    for (int i = 1; i <= 6; i++) begin
      step();
      tests_run++;
      if (sample_valid !== (i == 4) || sample_err !== 1'b0) begin
        tests_failed++;
        $display("FAIL timeout_recover_strobe T+%0d: got v=%b e=%b, want v=%b e=0",
                 i, sample_valid, sample_err, (i == 4));
      end
    end
    tests_run++;
    if (ypos_out !== 12'd11 || xpos_out !== 12'd5 || ypos_out_sec !== 10'd7) begin
      tests_failed++;
      $display("FAIL timeout_recover_values: got x=%0d y=%0d ys=%0d, want 5 11 7",
               xpos_out, ypos_out, ypos_out_sec);
    end
  endtask

  task automatic test_click();
    logic [3:0] btn_seq;
    logic [3:0] pulse_exp;
    btn_seq   = 4'b1011;  // frames 0..3 use bits 0..3: 1,1,0,1
    pulse_exp = 4'b1001;  // pulse on frames 0 and 3 only
    for (int f = 0; f < 4; f++) begin
      mouse_left_in = btn_seq[f];
      start_frame();
      for (int i = 1; i <= 6; i++) begin
        step();
        tests_run++;
        if (click_pulse !== (i == 4 && pulse_exp[f]) || sample_valid !== (i == 4)) begin
          tests_failed++;
          $display("FAIL click frame%0d T+%0d: got click=%b v=%b, want click=%b v=%b",
                   f, i, click_pulse, sample_valid, (i == 4 && pulse_exp[f]), (i == 4));
        end
      end
    end
  endtask

  task automatic test_hold_high();
    // vblank is still high from the last frame: no further samples.
    ypos_in = 12'd123;
    for (int i = 0; i < 20; i++) begin
      step();
      tests_run++;
      if (sample_valid !== 1'b0 || sample_err !== 1'b0 || ypos_out !== 12'd11) begin
        tests_failed++;
        $display("FAIL hold_high cyc%0d: got v=%b e=%b y=%0d, want 0 0 11",
                 i, sample_valid, sample_err, ypos_out);
      end
    end
  endtask

  task automatic test_reset_mid_settle();
    xpos_in = 12'd1; ypos_in = 12'd2; ypos_in_sec = 10'd3; mouse_left_in = 1'b0;
    start_frame();
    step();
    step();
    rst = 1'b1; vblank_in = 1'b0;
    step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      tests_run++;
      if ({xpos_out, ypos_out, ypos_out_sec, click_pulse, sample_valid, sample_err} !== 37'd0) begin
        tests_failed++;
        $display("FAIL rst_mid_settle cyc%0d: got x=%0d y=%0d v=%b e=%b, want all 0",
                 i, xpos_out, ypos_out, sample_valid, sample_err);
      end
    end
    xpos_in = 12'd9; ypos_in = 12'd8; ypos_in_sec = 10'd7; mouse_left_in = 1'b1;
    start_frame();
    for (int i = 1; i <= 4; i++) step();
    tests_run++;
    if (sample_valid !== 1'b1 || xpos_out !== 12'd9 || ypos_out !== 12'd8 ||
        ypos_out_sec !== 10'd7 || click_pulse !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_resample: got v=%b x=%0d y=%0d ys=%0d click=%b, want 1 9 8 7 1",
               sample_valid, xpos_out, ypos_out, ypos_out_sec, click_pulse);
    end
    step();
    tests_run++;
    if (sample_valid !== 1'b0 || click_pulse !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_resample_width: got v=%b click=%b, want 0 0", sample_valid, click_pulse);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_basic_sample();
    test_clamp();
    test_timeout();
    test_click();
    test_hold_high();
    test_reset_mid_settle();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
